// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared types and helpers for the bit-serial comparator
package comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_GT   = 2'd1,
    DEC_LT   = 2'd2
  } dec_t;

  // Decision at a differing bit; inv flips the sense at a signed MSB.
  function automatic dec_t bit_decide(input logic a_bit, input logic inv);
    return (a_bit ^ inv) ? DEC_GT : DEC_LT;
  endfunction

  // One-hot flag vector {GT, LT, EQ}.
  function automatic logic [2:0] dec_flags(input dec_t d);
    logic [2:0] f;
    case (d)
      DEC_GT:  f = 3'b100;
      DEC_LT:  f = 3'b010;
      default: f = 3'b001;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparator_serial_signed.sv
// rtl/comparator_serial_signed.sv - MSB-first bit-serial signed/unsigned comparator
// Optional build macro: COMPARATOR_SERIAL_EARLY_EXIT_EN (finish on first differing bit).
module comparator_serial_signed
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             A_GREATER_B,
  output logic             A_LESS_B,
  output logic             A_EQUAL_B
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  dec_t               dec_q, dec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         flags_q, flags_d;

  dec_t               dec_n;
  logic               finish;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    flags_d = flags_q;
    dec_n   = dec_q;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = SIGNED;
          idx_d   = IDX_W'(WIDTH - 1);
          dec_d   = DEC_NONE;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the first differing bit (from the MSB) decides the outcome.
        if (dec_q == DEC_NONE && a_q[idx_q] != b_q[idx_q]) begin
          dec_n = bit_decide(a_q[idx_q], sgn_q && (idx_q == IDX_W'(WIDTH - 1)));
        end
        dec_d = dec_n;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        finish = (dec_n != DEC_NONE) || (idx_q == '0);
`else
        finish = (idx_q == '0);
`endif
        if (finish) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          flags_d = dec_flags(dec_n);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      dec_q   <= DEC_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flags_q <= flags_d;
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign A_GREATER_B = flags_q[2];
  assign A_LESS_B    = flags_q[1];
  assign A_EQUAL_B   = flags_q[0];

endmodule

// File: tb/tb_comparator_serial_signed.sv
// tb/tb_comparator_serial_signed.sv - bench for comparator_serial_signed at WIDTH 4 and 8
module tb_comparator_serial_signed;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start4 = 1'b0, sgn4 = 1'b0, start8 = 1'b0, sgn8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy4, done4, gt4, lt4, eq4;
  logic       busy8, done8, gt8, lt8, eq8;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  comparator_serial_signed #(.WIDTH(4)) u4 (
    .CLK(CLK), .RST(RST), .START(start4), .SIGNED(sgn4), .A(a4), .B(b4),
    .BUSY(busy4), .DONE(done4), .A_GREATER_B(gt4), .A_LESS_B(lt4), .A_EQUAL_B(eq4)
  );

  comparator_serial_signed #(.WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .START(start8), .SIGNED(sgn8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .A_GREATER_B(gt8), .A_LESS_B(lt8), .A_EQUAL_B(eq8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers and compare arithmetically.
  function automatic logic [2:0] ref_flags(input int w, input bit sgn,
                                           input logic [7:0] a, input logic [7:0] b);
    longint va = longint'(a);
    longint vb = longint'(b);
    if (sgn && a[w-1]) va = va - (longint'(1) << w);
    if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(input int w, input logic [7:0] a, input logic [7:0] b);
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    for (int i = w - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return w - i;
    end
`endif
    return w;
  endfunction

  function automatic logic [2:0] flags_of(input int w);
    return (w == 8) ? {gt8, lt8, eq8} : {gt4, lt4, eq4};
  endfunction

  task automatic drive(input int w, input logic st, input bit sgn,
                       input logic [7:0] a, input logic [7:0] b);
    if (w == 8) begin
      start8 = st; sgn8 = sgn; a8 = a; b8 = b;
    end else begin
      start4 = st; sgn4 = sgn; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  // Issues one request on the next negedge and waits for DONE.
  task automatic do_cmp(input int w, input bit sgn, input logic [7:0] a,
                        input logic [7:0] b, input string tag);
    int lat = 0;
    logic [2:0] exp_f = ref_flags(w, sgn, a, b);
    int exp_lat = ref_lat(w, a, b);
    logic d;
    @(negedge CLK);
    drive(w, 1'b1, sgn, a, b);
    @(posedge CLK); #1;
    drive(w, 1'b0, ~sgn, 8'($urandom), 8'($urandom));
    d = (w == 8) ? done8 : done4;
    while (!d && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      d = (w == 8) ? done8 : done4;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_flags"}, 32'(flags_of(w)), 32'(exp_f));
    chk({tag, "_busy"}, 32'((w == 8) ? busy8 : busy4), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    bit rs;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_flags", 32'({gt4, lt4, eq4}), 32'd0);
    chk("rst_flags8", 32'({gt8, lt8, eq8}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    do_cmp(4, 1'b1, 8'h0, 8'h8, "s_0_vs_m8");
    do_cmp(4, 1'b1, 8'h8, 8'hF, "s_m8_vs_m1");
    do_cmp(4, 1'b0, 8'h8, 8'hF, "u_8_vs_15");
    do_cmp(4, 1'b1, 8'h7, 8'h8, "s_7_vs_m8");
    do_cmp(4, 1'b0, 8'h7, 8'h8, "u_7_vs_8");
    do_cmp(4, 1'b1, 8'hE, 8'hE, "eq_m2");
    do_cmp(4, 1'b1, 8'hF, 8'hF, "eq_m1");

    repeat (3) @(posedge CLK);
    #1;
    chk("hold_flags", 32'({gt4, lt4, eq4}), 32'b001);
    chk("hold_done", 32'(done4), 32'd0);

    // START during a run must not disturb the captured operands.
    @(negedge CLK);
    drive(4, 1'b1, 1'b0, 8'h5, 8'h5);
    @(posedge CLK); #1;
    drive(4, 1'b0, 1'b0, 8'h0, 8'h0);
    @(negedge CLK);
    drive(4, 1'b1, 1'b1, 8'h0, 8'hF);
    @(negedge CLK);
    drive(4, 1'b0, 1'b1, 8'h0, 8'hF);
    lat = 1;
    while (!done4 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_flags", 32'({gt4, lt4, eq4}), 32'b001);

    // Back-to-back: the next request lands in the DONE cycle.
    do_cmp(4, 1'b1, 8'h3, 8'hC, "b2b_a");
    do_cmp(4, 1'b0, 8'hA, 8'hA, "b2b_b");
    do_cmp(4, 1'b1, 8'h1, 8'h2, "b2b_c");

    // Reset in the middle of a run.
    @(negedge CLK);
    drive(4, 1'b1, 1'b0, 8'h6, 8'h6);
    @(negedge CLK);
    drive(4, 1'b0, 1'b0, 8'h0, 8'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst_busy", 32'(busy4), 32'd0);
    chk("mid_rst_done", 32'(done4), 32'd0);
    chk("mid_rst_flags", 32'({gt4, lt4, eq4}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      chk("mid_rst_nodone", 32'(done4), 32'd0);
    end

    do_cmp(8, 1'b1, 8'h80, 8'h7F, "w8_s_m128_vs_127");
    do_cmp(8, 1'b0, 8'h80, 8'h7F, "w8_u_128_vs_127");

    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = 8'($urandom_range(0, 15));
      rb = (i % 5 == 0) ? ra : 8'($urandom_range(0, 15));
      do_cmp(4, rs, ra, rb, "rand4");
    end
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? ra : 8'($urandom);
      do_cmp(8, rs, ra, rb, "rand8");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
